// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// Slot fields are sized for the widest supported AW/TW; narrower values are zero-extended.
package hazard_pkg;

  localparam int HZ_AW_MAX    = 8;
  localparam int HZ_TW_MAX    = 4;

  localparam int FWD_RF       = 0;

  localparam int DEF_NSTAGE   = 3;
  localparam int DEF_AW       = 5;
  localparam int DEF_TW       = 2;
  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int DEF_EPC_ADDR = 14;

  typedef struct packed {
    logic                 valid;
    logic [HZ_AW_MAX-1:0] wa;
    logic [HZ_TW_MAX-1:0] tnew;
    logic                 mtc0;
    logic [HZ_AW_MAX-1:0] c0_wa;
  } hz_slot_t;

  // Tnew counts down by one per stage advanced and parks at zero once the result exists.
  function automatic logic [HZ_TW_MAX-1:0] tnew_dec(input logic [HZ_TW_MAX-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Mult/div busy down-counter: loads the unit latency on an accepted start,
// then counts to zero; busy while nonzero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: shadow pipeline of in-flight destinations, operand
// stall/forward selection, mult/div busy interlock and eret-after-mtc0-EPC interlock.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE   = DEF_NSTAGE,
  parameter int AW       = DEF_AW,
  parameter int TW       = DEF_TW,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int EPC_ADDR = DEF_EPC_ADDR,
  localparam int SW      = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_ra1,
  input  logic [AW-1:0] id_ra2,
  input  logic [TW-1:0] id_tuse1,
  input  logic [TW-1:0] id_tuse2,
  input  logic [AW-1:0] id_wa,
  input  logic [TW-1:0] id_tnew,
  input  logic          id_md_start,
  input  logic          id_md_is_div,
  input  logic          id_md_use,
  input  logic          id_mtc0,
  input  logic [AW-1:0] id_c0_wa,
  input  logic          id_eret,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_sel1,
  output logic [SW-1:0] fwd_sel2,
  output logic          md_busy
);

  hz_slot_t slot_q [NSTAGE];
  hz_slot_t slot_d [NSTAGE];

  logic          op1_stall;
  logic          op2_stall;
  logic [SW-1:0] sel1;
  logic [SW-1:0] sel2;
  logic          eret_hit;
  logic          md_stall;
  logic          md_start_ok;

  // Scan oldest to youngest so the youngest matching slot overwrites any older one.
  function automatic void op_check(
    input  logic [AW-1:0] ra,
    input  logic [TW-1:0] tuse,
    input  hz_slot_t      s [NSTAGE],
    output logic          stl,
    output logic [SW-1:0] sel
  );
    logic                 hit;
    logic [HZ_TW_MAX-1:0] t;
    int                   idx;
    hit = 1'b0;
    t   = '0;
    idx = 0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (s[i].valid && (s[i].wa == HZ_AW_MAX'(ra)) && (s[i].wa != '0)) begin
        hit = 1'b1;
        t   = s[i].tnew;
        idx = i;
      end
    end
    stl = hit && (t > HZ_TW_MAX'(tuse));
    sel = (hit && (t == '0)) ? SW'(idx + 1) : SW'(FWD_RF);
  endfunction

  always_comb begin
    op_check(id_ra1, id_tuse1, slot_q, op1_stall, sel1);
    op_check(id_ra2, id_tuse2, slot_q, op2_stall, sel2);

    eret_hit = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (slot_q[i].valid && slot_q[i].mtc0 &&
          (slot_q[i].c0_wa == HZ_AW_MAX'(EPC_ADDR))) begin
        eret_hit = 1'b1;
      end
    end

    md_stall = id_md_use && md_busy;
    stall    = id_valid && !flush && !reset &&
               (op1_stall || op2_stall || md_stall || (id_eret && eret_hit));

    fwd_sel1 = reset ? SW'(FWD_RF) : sel1;
    fwd_sel2 = reset ? SW'(FWD_RF) : sel2;

    md_start_ok = id_md_start && id_valid && !stall && !flush;
  end

  // Downstream slots keep moving during a stall; only slot 0 takes a bubble.
  always_comb begin
    for (int i = 0; i < NSTAGE; i++) begin
      slot_d[i] = '0;
    end
    if (!flush) begin
      if (id_valid && !stall) begin
        slot_d[0].valid = 1'b1;
        slot_d[0].wa    = HZ_AW_MAX'(id_wa);
        slot_d[0].tnew  = HZ_TW_MAX'(id_tnew);
        slot_d[0].mtc0  = id_mtc0;
        slot_d[0].c0_wa = HZ_AW_MAX'(id_c0_wa);
      end
      for (int i = 1; i < NSTAGE; i++) begin
        slot_d[i]      = slot_q[i-1];
        slot_d[i].tnew = tnew_dec(slot_q[i-1].tnew);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_ok),
    .is_div (id_md_is_div),
    .busy   (md_busy)
  );

endmodule
